// File: rtl/alarm_scheduler_if.sv
// Signal bundle between the time/key front end and the alarm scheduler.
// The master side drives time digits, setpoint and keys; the slave owns the buzzer.
interface alarm_scheduler_if;
    logic       sec_tick;
    logic [3:0] h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL;
    logic [3:0] al_hH, al_hL, al_mH, al_mL;
    logic       al_en;
    logic       key_snooze;
    logic       key_stop;
    logic       buzzer;
    logic       alarm_active;
    logic       snoozing;
    logic [1:0] snooze_cnt;

    modport master (
        output sec_tick, h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL,
        output al_hH, al_hL, al_mH, al_mL, al_en, key_snooze, key_stop,
        input  buzzer, alarm_active, snoozing, snooze_cnt
    );

    modport slave (
        input  sec_tick, h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL,
        input  al_hH, al_hL, al_mH, al_mL, al_en, key_snooze, key_stop,
        output buzzer, alarm_active, snoozing, snooze_cnt
    );
endinterface

// File: rtl/alarm_scheduler.sv
// Buzzer owner: arbitrates the user alarm (ring/snooze FSM) against the hourly chime,
// generating both tones from the 1 kHz system clock.
module alarm_scheduler #(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic               clk_1kHz,
    input  logic               rst,
    alarm_scheduler_if.slave   alm
);
    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

    localparam logic [7:0] RING_LIMIT   = 8'(RING_SECS);
    localparam logic [9:0] SNOOZE_LOAD  = 10'(SNOOZE_MIN * 60);
    localparam logic [1:0] SNOOZE_LIMIT = 2'(MAX_SNOOZE);

    state_t     state, stateNext;
    logic [1:0] divCnt;
    logic       toneHi, toneLo;
    logic       match, matchD, trigger;
    logic [7:0] ringSec, ringSecNext;
    logic [9:0] snzTmr, snzTmrNext;
    logic [1:0] snoozeCnt, snoozeCntNext;
    logic       gate, gateNext;
    logic       chimeMin, chimeLo, chimeHi;
    logic       buzzerNext, buzzerReg;

    assign toneHi = divCnt[0];
    assign toneLo = divCnt[1];

    // Edge-detect the match so the alarm fires once, at the first cycle of hh:mm:00.
    assign match = (alm.h_cntH == alm.al_hH) && (alm.h_cntL == alm.al_hL) &&
                   (alm.m_cntH == alm.al_mH) && (alm.m_cntL == alm.al_mL) &&
                   (alm.s_cntH == 4'd0)      && (alm.s_cntL == 4'd0);
    assign trigger = match & ~matchD;

    always_comb begin
        stateNext     = state;
        ringSecNext   = ringSec;
        snzTmrNext    = snzTmr;
        snoozeCntNext = snoozeCnt;
        gateNext      = gate;
        if (!alm.al_en) begin
            stateNext     = IDLE;
            snoozeCntNext = 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trigger) begin
                        stateNext     = RINGING;
                        ringSecNext   = 8'd0;
                        snoozeCntNext = 2'd0;
                        gateNext      = 1'b1;
                    end
                end
                RINGING: begin
                    if (alm.key_stop) begin
                        stateNext     = IDLE;
                        snoozeCntNext = 2'd0;
                    end else if (alm.key_snooze && (snoozeCnt < SNOOZE_LIMIT)) begin
                        stateNext     = SNOOZE;
                        snoozeCntNext = snoozeCnt + 2'd1;
                        snzTmrNext    = SNOOZE_LOAD;
                    end else if (alm.sec_tick) begin
                        ringSecNext = ringSec + 8'd1;
                        gateNext    = ~gate;
                        if (ringSec + 8'd1 == RING_LIMIT) begin
                            stateNext     = IDLE;
                            snoozeCntNext = 2'd0;
                        end
                    end
                end
                SNOOZE: begin
                    if (alm.key_stop) begin
                        stateNext     = IDLE;
                        snoozeCntNext = 2'd0;
                    end else if (alm.sec_tick) begin
                        snzTmrNext = snzTmr - 10'd1;
                        if (snzTmr == 10'd1) begin
                            stateNext   = RINGING;
                            ringSecNext = 8'd0;
                            gateNext    = 1'b1;
                        end
                    end
                end
                default: begin
                    stateNext     = IDLE;
                    snoozeCntNext = 2'd0;
                end
            endcase
        end
    end

    // Chime pips: three low pips at 59:51/53/55, one high pip at 59:57.
    assign chimeMin = (alm.m_cntH == 4'd5) && (alm.m_cntL == 4'd9) && (alm.s_cntH == 4'd5);
    assign chimeLo  = chimeMin && ((alm.s_cntL == 4'd1) || (alm.s_cntL == 4'd3) ||
                                   (alm.s_cntL == 4'd5));
    assign chimeHi  = chimeMin && (alm.s_cntL == 4'd7);

    always_comb begin
        buzzerNext = 1'b0;
        if (stateNext == RINGING)
            buzzerNext = gateNext & toneHi;
        else if (chimeLo)
            buzzerNext = toneLo;
        else if (chimeHi)
            buzzerNext = toneHi;
    end

    always_ff @(posedge clk_1kHz or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            divCnt    <= 2'd0;
            matchD    <= 1'b1;
            ringSec   <= 8'd0;
            snzTmr    <= 10'd0;
            snoozeCnt <= 2'd0;
            gate      <= 1'b0;
            buzzerReg <= 1'b0;
        end else begin
            state     <= stateNext;
            divCnt    <= divCnt + 2'd1;
            matchD    <= match;
            ringSec   <= ringSecNext;
            snzTmr    <= snzTmrNext;
            snoozeCnt <= snoozeCntNext;
            gate      <= gateNext;
            buzzerReg <= buzzerNext;
        end
    end

    assign alm.buzzer       = buzzerReg;
    assign alm.alarm_active = (state == RINGING);
    assign alm.snoozing     = (state == SNOOZE);
    assign alm.snooze_cnt   = snoozeCnt;
endmodule
